// File: rtl/cafe_pkg.sv
// cafe_pkg: shared encodings for the coffee machine controller and plant.
// Motor command values and the plant's cup-position states.
package cafe_pkg;

    localparam logic [1:0] M_IDLE  = 2'b00;
    localparam logic [1:0] M_ADV   = 2'b01;
    localparam logic [1:0] M_EJECT = 2'b10;
    localparam logic [1:0] M_BAD   = 2'b11;

    typedef enum logic [2:0] {
        EMPTY,
        LOADED,
        MOVING,
        AT_SPOUT,
        EJECTING
    } cup_state_t;

endpackage

// File: rtl/cafe_if.sv
// cafe_if: actuator commands and sensor flags between coffee controller
// and machine (real or plant model).
interface cafe_if;

    logic       cup_in;
    logic [1:0] M;
    logic       G;
    logic       C;
    logic       S2;
    logic       S1;
    logic       S0;
    logic       fault;

    modport master (
        output cup_in, M, G, C,
        input  S2, S1, S0, fault
    );

    modport slave (
        input  cup_in, M, G, C,
        output S2, S1, S0, fault
    );

endinterface

// File: rtl/cafe_sat_counter.sv
// cafe_sat_counter: up/down counter saturating at 0 and MAX, sync clear,
// with a registered at-max flag.
module cafe_sat_counter #(
    parameter int unsigned CW  = 8,
    parameter int unsigned MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic up,
    input  logic dn,
    output logic full
);

    localparam logic [CW-1:0] MAXV = CW'(MAX);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (clr)
            cnt_nxt = '0;
        else if (up && !dn && cnt != MAXV)
            cnt_nxt = cnt + 1'b1;
        else if (dn && !up && cnt != '0)
            cnt_nxt = cnt - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            full <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            full <= (cnt_nxt == MAXV);
        end
    end

endmodule

// File: rtl/cafe_plant.sv
// cafe_plant: self-timed model of the coffee machine mechanics, answering
// the controller's M/G/C commands with S2/S1/S0 sensor flags.
module cafe_plant
    import cafe_pkg::*;
#(
    parameter int unsigned MOVE_CYCLES = 3,
    parameter int unsigned HEAT_CYCLES = 8,
    parameter int unsigned POUR_CYCLES = 5,
    parameter int unsigned CW          = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    cafe_if.slave  bus
);

    localparam logic [CW-1:0] MV_LOAD = CW'(MOVE_CYCLES - 1);

    cup_state_t    state;
    logic [CW-1:0] mv;
    logic          bad;
    logic          pour_up;
    logic          pour_clr;

    assign bad = (bus.M == M_BAD)
               | (bus.C && state != AT_SPOUT)
               | (bus.M == M_EJECT && (state == EMPTY || state == LOADED));

    // pour only counts when the water was already hot at this edge
    assign pour_up  = bus.C && bus.S1 && state == AT_SPOUT;
    assign pour_clr = (state == EJECTING) && (mv == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            mv        <= '0;
            bus.S2    <= 1'b0;
            bus.fault <= 1'b0;
        end else begin
            bus.fault <= bus.fault | bad;
            unique case (state)
                EMPTY: if (bus.cup_in) begin
                    state  <= LOADED;
                    bus.S2 <= 1'b1;
                end
                LOADED: if (bus.M == M_ADV) begin
                    state  <= MOVING;
                    mv     <= MV_LOAD;
                    bus.S2 <= 1'b0;
                end
                MOVING: begin
                    if (mv == '0) state <= AT_SPOUT;
                    else          mv    <= mv - 1'b1;
                end
                AT_SPOUT: if (bus.M == M_EJECT) begin
                    state <= EJECTING;
                    mv    <= MV_LOAD;
                end
                EJECTING: begin
                    if (mv == '0) state <= EMPTY;
                    else          mv    <= mv - 1'b1;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    cafe_sat_counter #(.CW(CW), .MAX(HEAT_CYCLES)) u_heat (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .up    (bus.G),
        .dn    (!bus.G),
        .full  (bus.S1)
    );

    cafe_sat_counter #(.CW(CW), .MAX(POUR_CYCLES)) u_pour (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pour_clr),
        .up    (pour_up),
        .dn    (1'b0),
        .full  (bus.S0)
    );

endmodule
